mem_port_arbiter: RTL

Sequences a single-ported unified memory shared by the instruction-fetch stage and the data-memory stage of the five-stage DLX pipeline. Latches one request at a time, holds address, data and control stable on the memory port for a fixed latency, then returns read data with a one-cycle acknowledge. Emits per-requester stall signals that the pipeline uses to freeze PC and the interstage registers while a request is pending.

---
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory sequencer shared by the DLX fetch and data stages.
// Define MEM_ARB_RR_EN to alternate ties between requesters instead of fixed data priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              if_stall,
  output logic              dm_stall,
  output logic              pipe_stall
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                grant_dm;
`ifdef MEM_ARB_RR_EN
  logic                last_q, last_d;
`endif

  // owner/last encoding: 1 = data stage, 0 = fetch stage
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    owner_d    = owner_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    grant_dm   = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          if (if_req && dm_req) begin
`ifdef MEM_ARB_RR_EN
            grant_dm = ~last_q;
`else
            grant_dm = 1'b1;
`endif
          end else begin
            grant_dm = dm_req;
          end
          addr_d  = grant_dm ? dm_addr : if_addr;
          wdata_d = grant_dm ? dm_wdata : '0;
          we_d    = grant_dm & dm_we;
          owner_d = grant_dm;
          cnt_d   = 4'(MEM_LAT - 1);
          state_d = BUSY;
`ifdef MEM_ARB_RR_EN
          last_d  = grant_dm;
`endif
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          // stores leave the data-side read register untouched
          if (!we_q) begin
            if (owner_q) dm_rdata_d = mem_rdata;
            else         if_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      owner_q    <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      owner_q    <= owner_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  assign mem_cs     = (state_q == BUSY);
  assign mem_we     = (state_q == BUSY) & we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign if_ack     = (state_q == RESP) & ~owner_q;
  assign dm_ack     = (state_q == RESP) & owner_q;
  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;
  assign if_stall   = if_req & ~if_ack;
  assign dm_stall   = dm_req & ~dm_ack;
  assign pipe_stall = if_stall | dm_stall;

endmodule
